// File: rtl/extract_trigger_from_tlast_pkg.sv
// Shared types and constants for the tlast/trigger stream blocks
// (playback and acquisition sides).
package extract_trigger_from_tlast_pkg;

    localparam int unsigned ETT_COUNT_WIDTH   = 32;
    localparam int unsigned ETT_TRIGGER_WIDTH = 32;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } ett_state_t;

endpackage

// File: rtl/extract_trigger_from_tlast_prims.sv
// Small storage primitives: an enabled register with a parameterized reset
// value, and a clear/increment counter. Both use a synchronous active-high reset.
module extract_trigger_from_tlast_reg #(
    parameter int unsigned     WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RESET_VALUE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// Clear takes priority over increment; the count wraps modulo 2^WIDTH.
module extract_trigger_from_tlast_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/extract_trigger_from_tlast.sv
// Forwards tlast-framed DMA packets as an unframed stream to the DAC path,
// pulses a trigger at a chosen beat of each packet and stops after N packets.
module extract_trigger_from_tlast
    import extract_trigger_from_tlast_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = ETT_COUNT_WIDTH
) (
    input  logic                         stream_clk,
    input  logic                         stream_reset,
    input  logic                         start,
    input  logic [COUNT_WIDTH-1:0]       packet_count,
    input  logic [COUNT_WIDTH-1:0]       trigger_beat,
    input  logic [ETT_TRIGGER_WIDTH-1:0] trigger_select,
    output logic                         idle,
    output logic [COUNT_WIDTH-1:0]       packets_done,
    output logic [COUNT_WIDTH-1:0]       last_length,
    output logic                         underrun,
    input  logic [DATA_WIDTH-1:0]        s_tdata,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic                         s_tlast,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [ETT_TRIGGER_WIDTH-1:0] trigger
);

    logic [0:0]                   r_state_q;
    ett_state_t                   w_state;
    ett_state_t                   w_state_next;
    logic                         w_streaming;
    logic                         w_start_accept;
    logic                         w_beat;
    logic                         w_tlast_beat;
    logic                         w_trig_hit;
    logic                         w_underrun_set;
    logic [COUNT_WIDTH-1:0]       r_beat_count;
    logic [COUNT_WIDTH-1:0]       r_packets_done;
    logic [COUNT_WIDTH-1:0]       r_last_length;
    logic [0:0]                   r_underrun;
    logic [ETT_TRIGGER_WIDTH-1:0] r_trigger;
    logic [COUNT_WIDTH-1:0]       w_done_next;
    logic [COUNT_WIDTH-1:0]       w_packet_limit;
    logic [ETT_TRIGGER_WIDTH-1:0] w_trigger_d;

    assign w_state     = ett_state_t'(r_state_q);
    assign w_streaming = (w_state == S_STREAM);

    // Combinational pass-through; the sink is only ever offered data while streaming.
    assign m_tdata  = w_streaming ? s_tdata : '0;
    assign m_tvalid = w_streaming & s_tvalid;
    assign s_tready = w_streaming & m_tready;

    assign w_beat         = w_streaming & s_tvalid & m_tready;
    assign w_tlast_beat   = w_beat & s_tlast;
    assign w_trig_hit     = w_beat & (r_beat_count == trigger_beat);
    assign w_underrun_set = w_streaming & (r_beat_count != '0) & m_tready & ~s_tvalid;
    assign w_done_next    = r_packets_done + COUNT_WIDTH'(1);
    assign w_packet_limit = (packet_count == '0) ? COUNT_WIDTH'(1) : packet_count;
    assign w_trigger_d    = w_trig_hit ? trigger_select : '0;

    // Next-state logic
    always_comb begin
        w_state_next   = w_state;
        w_start_accept = 1'b0;
        case (w_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next   = S_STREAM;
                    w_start_accept = 1'b1;
                end
            end
            S_STREAM: begin
                if (w_tlast_beat && (w_done_next >= w_packet_limit)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    extract_trigger_from_tlast_reg #(
        .WIDTH       (1),
        .RESET_VALUE (1'(S_IDLE))
    ) u_state_reg (
        .i_clk (stream_clk),
        .i_rst (stream_reset),
        .i_en  (1'b1),
        .i_d   (1'(w_state_next)),
        .o_q   (r_state_q)
    );

    extract_trigger_from_tlast_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_beat_counter (
        .i_clk   (stream_clk),
        .i_rst   (stream_reset),
        .i_clear (w_start_accept | w_tlast_beat),
        .i_inc   (w_beat),
        .o_count (r_beat_count)
    );

    extract_trigger_from_tlast_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_packet_counter (
        .i_clk   (stream_clk),
        .i_rst   (stream_reset),
        .i_clear (w_start_accept),
        .i_inc   (w_tlast_beat),
        .o_count (r_packets_done)
    );

    extract_trigger_from_tlast_reg #(
        .WIDTH (COUNT_WIDTH)
    ) u_last_length_reg (
        .i_clk (stream_clk),
        .i_rst (stream_reset),
        .i_en  (w_tlast_beat),
        .i_d   (r_beat_count + COUNT_WIDTH'(1)),
        .o_q   (r_last_length)
    );

    // Sticky until the next start; set and clear never coincide since start is only taken in idle.
    extract_trigger_from_tlast_reg #(
        .WIDTH (1)
    ) u_underrun_reg (
        .i_clk (stream_clk),
        .i_rst (stream_reset),
        .i_en  (w_start_accept | w_underrun_set),
        .i_d   (w_underrun_set),
        .o_q   (r_underrun)
    );

    extract_trigger_from_tlast_reg #(
        .WIDTH (ETT_TRIGGER_WIDTH)
    ) u_trigger_reg (
        .i_clk (stream_clk),
        .i_rst (stream_reset),
        .i_en  (1'b1),
        .i_d   (w_trigger_d),
        .o_q   (r_trigger)
    );

    assign idle         = ~w_streaming;
    assign packets_done = r_packets_done;
    assign last_length  = r_last_length;
    assign underrun     = r_underrun[0];
    assign trigger      = r_trigger;

endmodule

// File: tb/tb_extract_trigger_from_tlast.sv
// Randomized bench for extract_trigger_from_tlast with a packet-level reference model.
module tb_extract_trigger_from_tlast;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] packet_count = '0;
    logic [CW-1:0] trigger_beat = '0;
    logic [31:0]   trigger_select = '0;
    logic          idle;
    logic [CW-1:0] packets_done;
    logic [CW-1:0] last_length;
    logic          underrun;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [31:0]   trigger;

    extract_trigger_from_tlast #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .stream_clk     (clk),
        .stream_reset   (rst),
        .start          (start),
        .packet_count   (packet_count),
        .trigger_beat   (trigger_beat),
        .trigger_select (trigger_select),
        .idle           (idle),
        .packets_done   (packets_done),
        .last_length    (last_length),
        .underrun       (underrun),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tlast        (s_tlast),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .trigger        (trigger)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    bit chk_en = 1'b0;
    int pulses = 0;

    // Reference model: run flag, beat position in packet, per-run tallies.
    bit          mdl_run = 1'b0;
    logic [CW-1:0] mdl_pos = '0;
    logic [CW-1:0] mdl_done = '0;
    logic [CW-1:0] mdl_len = '0;
    bit          mdl_under = 1'b0;
    logic [31:0] mdl_trig = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mdl_run = 0; mdl_pos = '0; mdl_done = '0; mdl_len = '0;
            mdl_under = 0; mdl_trig = '0;
        end else begin
            mdl_trig = '0;
            if (!mdl_run) begin
                if (start) begin
                    mdl_run = 1; mdl_pos = '0; mdl_done = '0; mdl_under = 0;
                end
            end else begin
                if (m_tready && !s_tvalid && mdl_pos != 0) mdl_under = 1;
                if (s_tvalid && m_tready) begin
                    if (mdl_pos == trigger_beat) mdl_trig = trigger_select;
                    if (s_tlast) begin
                        mdl_len  = mdl_pos + 1;
                        mdl_done = mdl_done + 1;
                        mdl_pos  = '0;
                        if (mdl_done >= ((packet_count == 0) ? CW'(1) : packet_count)) mdl_run = 0;
                    end else begin
                        mdl_pos = mdl_pos + 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("idle", 64'(idle), 64'(!mdl_run));
            chk("packets_done", 64'(packets_done), 64'(mdl_done));
            chk("last_length", 64'(last_length), 64'(mdl_len));
            chk("underrun", 64'(underrun), 64'(mdl_under));
            chk("trigger", 64'(trigger), 64'(mdl_trig));
            chk("m_tvalid", 64'(m_tvalid), 64'(mdl_run && s_tvalid));
            chk("s_tready", 64'(s_tready), 64'(mdl_run && m_tready));
            chk("m_tdata", 64'(m_tdata), mdl_run ? 64'(s_tdata) : 64'd0);
            if (trigger != 0) pulses++;
        end
    end

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm(input int pc, input int tb, input logic [31:0] sel);
        packet_count = CW'(pc); trigger_beat = CW'(tb); trigger_select = sel;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Sends one packet; beats are counted as accepted using the model's run flag.
    task automatic send_pkt(input int len, input int rdy_pct, input int gap_at, input int gap_len);
        int i = 0;
        int guard = 0;
        int gap = 0;
        bit acc;
        while (i < len && guard < 2000) begin
            s_tvalid = 1'b1;
            if (i == gap_at && gap < gap_len) begin
                s_tvalid = 1'b0;
                gap++;
            end
            s_tdata  = $urandom;
            s_tlast  = (i == len - 1);
            m_tready = ($urandom_range(99) < rdy_pct);
            acc = s_tvalid && m_tready && mdl_run;
            step(1);
            if (acc) i++;
            guard++;
        end
        if (guard >= 2000) chk("send_pkt_timeout", 64'(i), 64'(len));
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset_idle", 64'(idle), 64'd1);
        chk("reset_trigger", 64'(trigger), 64'd0);
        chk("reset_s_tready", 64'(s_tready), 64'd0);

        // Idle: data offered is ignored
        m_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = k[0];
            step(1);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        chk("idle_packets_done", 64'(packets_done), 64'd0);
        chk("idle_last_length", 64'(last_length), 64'd0);

        // Two 8-beat packets, trigger at beat 3
        pulses = 0;
        arm(2, 3, 32'h5);
        send_pkt(8, 100, -1, 0);
        send_pkt(8, 100, -1, 0);
        step(2);
        chk("two_pkt_idle", 64'(idle), 64'd1);
        chk("two_pkt_done", 64'(packets_done), 64'd2);
        chk("two_pkt_len", 64'(last_length), 64'd8);
        chk("two_pkt_pulses", 64'(pulses), 64'd2);
        s_tvalid = 1'b1; m_tready = 1'b1;
        step(3);
        chk("third_pkt_held", 64'(s_tready), 64'd0);
        s_tvalid = 1'b0;

        // 16 beats under random backpressure
        pulses = 0;
        arm(1, 5, 32'hA5);
        send_pkt(16, 50, -1, 0);
        step(2);
        chk("bp_pulses", 64'(pulses), 64'd1);
        chk("bp_len", 64'(last_length), 64'd16);

        // Starvation mid-packet sets a sticky underrun
        arm(1, 100, 32'h1);
        send_pkt(8, 100, 3, 2);
        step(3);
        chk("underrun_set", 64'(underrun), 64'd1);
        arm(1, 100, 32'h1);
        chk("underrun_cleared", 64'(underrun), 64'd0);
        send_pkt(2, 100, -1, 0);
        step(1);

        // Trigger beat beyond packet length; single-beat packet at beat 0
        pulses = 0;
        arm(1, 10, 32'h7);
        send_pkt(4, 100, -1, 0);
        step(2);
        chk("no_pulse_short_pkt", 64'(pulses), 64'd0);
        arm(0, 0, 32'h9);
        send_pkt(1, 100, -1, 0);
        step(2);
        chk("single_beat_pulse", 64'(pulses), 64'd1);
        chk("single_beat_len", 64'(last_length), 64'd1);
        chk("single_beat_idle", 64'(idle), 64'd1);

        // Randomized runs
        for (int r = 0; r < 25; r++) begin
            int pc;
            pc = $urandom_range(3);
            arm(pc, $urandom_range(7), $urandom);
            for (int p = 0; p < ((pc == 0) ? 1 : pc); p++) begin
                send_pkt($urandom_range(1, 10), $urandom_range(30, 100),
                         ($urandom_range(3) == 0) ? $urandom_range(1, 4) : -1,
                         $urandom_range(1, 2));
            end
            step(2);
        end

        // Reset mid-packet at beat 5
        arm(1, 2, 32'h3);
        s_tvalid = 1'b1; m_tready = 1'b1; s_tlast = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_tdata = $urandom;
            step(1);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0; s_tvalid = 1'b0;
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_packets_done", 64'(packets_done), 64'd0);
        chk("rst_last_length", 64'(last_length), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        step(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/extract_trigger_from_tlast.md
# extract_trigger_from_tlast

Playback-side counterpart to the acquisition trigger path. It accepts tlast-framed AXI4-Stream packets from the MM2S DMA and forwards them as an unframed continuous stream to the DAC datapath. It also emits a one-cycle trigger pulse at a software-selected beat offset within every packet, and stops after a programmed number of packets. It sits between the DMA and the DAC formatter, in the DAC stream clock domain.

## Interface
Parameters:
- DATA_WIDTH, 32, width of s_tdata/m_tdata
- COUNT_WIDTH, 32, width of beat/packet counters and count registers

Ports:
- stream_clk  in  1  stream clock; all logic is on its rising edge
- stream_reset  in  1  reset, synchronous and active-high
- start  in  1  level; in S_IDLE, arms the block; ignored in any other state
- packet_count  in  COUNT_WIDTH  packets to forward per run; 0 is treated as 1
- trigger_beat  in  COUNT_WIDTH  0-based beat index within a packet at which the trigger fires
- trigger_select  in  32  trigger bits driven on a trigger event
- idle  out  1  high in S_IDLE
- packets_done  out  COUNT_WIDTH  completed packets in the current or most recent run
- last_length  out  COUNT_WIDTH  beat count of the most recently completed packet
- underrun  out  1  sticky; upstream starved the sink mid-packet
- s_tdata/s_tvalid/s_tready/s_tlast  in/in/out/in  DATA_WIDTH/1/1/1  AXI4-Stream slave (from DMA)
- m_tdata/m_tvalid/m_tready  out/out/in  DATA_WIDTH/1/1  AXI4-Stream master (to DAC path); has no tlast
- trigger  out  32  registered trigger pulse bits

## Operation
- States: S_IDLE=0, S_STREAM=1.
- S_IDLE:
  - s_tready=0, m_tvalid=0, m_tdata=0, trigger=0.
  - start=1 → S_STREAM on the next cycle. On this transition, clear packets_done, beat_count and underrun. last_length holds.
- S_STREAM:
  - Pass-through: m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready. All three are combinational.
  - beat = s_tvalid & m_tready.
  - beat_count increments on each beat and returns to 0 on a beat with s_tlast=1.
- Trigger: on a beat where beat_count==trigger_beat, trigger=trigger_select on the next cycle, then 0.
  - If trigger_beat ≥ packet length, no pulse fires for that packet.
- Packet end (beat with s_tlast=1):
  - last_length <= beat_count+1.
  - packets_done <= packets_done+1.
  - If packets_done+1 ≥ max(packet_count,1) → S_IDLE. Data arriving afterwards is held off because s_tready=0.
- Underrun: in S_STREAM, set when beat_count≠0 & m_tready=1 & s_tvalid=0. Held until the next start acceptance.
- Counter arithmetic is unsigned and wraps modulo 2^COUNT_WIDTH with no saturation. A packet longer than 2^COUNT_WIDTH beats is unsupported.
- Configuration inputs are sampled live. Software changes them only while idle=1.

## Timing
- Reset values: state=S_IDLE, idle=1, packets_done=0, last_length=0, underrun=0, trigger=0, m_tvalid=0, s_tready=0.
- Reset mid-packet aborts immediately. The partial packet is not counted, and the remainder of the DMA packet is the responsibility of software (DMA reset).
- Data path latency is 0 cycles (combinational).
- trigger, packets_done, last_length and underrun update 1 cycle after the qualifying beat or cycle.
- idle rises the cycle after the final tlast beat.
- A simultaneous trigger beat and tlast beat are both honoured: the trigger pulses and the packet closes.
- A single-beat packet (tlast on beat 0) gives last_length=1. It fires the trigger only if trigger_beat=0.
- Back-to-back packets need no gap: beat 0 of the next packet may follow the tlast beat on the next cycle.
- Handshake: m_tvalid never depends on m_tready. s_tready deasserts combinationally in the state after the final tlast.

## Structure
- Shared package: state encodings, and a COUNT_WIDTH default constant shared with the acquisition-side trigger/tlast block.
- Reuse the team's counter primitive for beat_count and packets_done.
- Reuse the team's register primitive for the state, trigger, last_length and underrun registers.
- No new sub-module is required. The top is a single FSM plus counters, roughly 150–200 lines.

## Test plan
- Reset, then idle: idle=1, s_tready=0, trigger=0. Drive s_tvalid=1 with data → no m_tvalid, no counters change.
- packet_count=2, trigger_beat=3, trigger_select=0x5, two 8-beat packets with m_tready=1 → trigger=0x5 exactly one cycle after beat 3 of each packet, last_length=8, packets_done=2, idle=1 after the second tlast, the third packet is not accepted.
- Random m_tready backpressure on a 16-beat packet → m_tdata sequence identical to input, trigger is one pulse, last_length=16.
- s_tvalid dropped for 2 cycles mid-packet with m_tready=1 → underrun=1 and it stays set; next start → underrun=0.
- trigger_beat=10 with a 4-beat packet → no trigger pulse. trigger_beat=0 with a 1-beat packet → one pulse and last_length=1.
- stream_reset asserted at beat 5 of 8 → all outputs return to reset values the next cycle, packets_done=0, idle=1.
